regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_arbiter.sv | 111 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back scheduler for the integer register file, with a pending-write scoreboard.
// Latency: grant to register-file write is 1 cycle; stall and readies are combinational.
// Backpressure: a requester holds valid/rd/data until its ready; one grant per cycle.
module regfile_wb_arbiter #(
    parameter int XLEN = 64
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_alu_valid,
    output logic            o_alu_ready,
    input  logic [4:0]      i_alu_rd,
    input  logic [XLEN-1:0] i_alu_data,
    input  logic            i_ld_valid,
    output logic            o_ld_ready,
    input  logic [4:0]      i_ld_rd,
    input  logic [XLEN-1:0] i_ld_data,
    input  logic            i_issue_valid,
    input  logic            i_issue_has_rd,
    input  logic [4:0]      i_issue_rd,
    input  logic [4:0]      i_rs1,
    input  logic [4:0]      i_rs2,
    output logic            o_stall,
    output logic [31:0]     o_busy,
    output logic            o_we,
    output logic [4:0]      o_rd,
    output logic [XLEN-1:0] o_data
);

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LD  = 1'b1
    } src_t;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

    src_t            last;
    src_t            last_next;
    wb_req_t         sel_req;
    logic            grant;
    logic            issue_ok;
    logic [31:0]     busy;
    logic [31:0]     busy_next;

    // On a tie the side that did not win last time takes the port.
    always_comb begin
        o_alu_ready = 1'b0;
        o_ld_ready  = 1'b0;
        if (!i_reset) begin
            o_alu_ready = i_alu_valid && (!i_ld_valid || last == SRC_LD);
            o_ld_ready  = i_ld_valid && (!i_alu_valid || last == SRC_ALU);
        end
    end

    assign grant = o_alu_ready || o_ld_ready;

    always_comb begin
        sel_req = '{rd: i_ld_rd, data: i_ld_data};
        if (o_alu_ready) begin
            sel_req = '{rd: i_alu_rd, data: i_alu_data};
        end
    end

    always_comb begin
        last_next = last;
        if (o_alu_ready) begin
            last_next = SRC_ALU;
        end else if (o_ld_ready) begin
            last_next = SRC_LD;
        end
    end

    assign o_stall  = i_issue_valid &&
                      (busy[i_rs1] || busy[i_rs2] || (i_issue_has_rd && busy[i_issue_rd]));
    assign issue_ok = i_issue_valid && !o_stall;

    // Clear first so a same-edge set of the same register wins.
    always_comb begin
        busy_next = busy;
        if (o_we) begin
            busy_next[o_rd] = 1'b0;
        end
        if (issue_ok && i_issue_has_rd && i_issue_rd != 5'd0) begin
            busy_next[i_issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            last   <= SRC_LD;
            busy   <= '0;
            o_we   <= 1'b0;
            o_rd   <= '0;
            o_data <= '0;
        end else begin
            last <= last_next;
            busy <= busy_next;
            o_we <= grant && (sel_req.rd != 5'd0);
            if (grant) begin
                o_rd   <= sel_req.rd;
                o_data <= sel_req.data;
            end
        end
    end

    assign o_busy = busy;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration, write stage, scoreboard and reset.
module tb_regfile_wb_arbiter;

    localparam int XLEN = 64;

    logic            clk;
    logic            reset;
    logic            alu_valid;
    logic            alu_ready;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            ld_valid;
    logic            ld_ready;
    logic [4:0]      ld_rd;
    logic [XLEN-1:0] ld_data;
    logic            issue_valid;
    logic            issue_has_rd;
    logic [4:0]      issue_rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            stall;
    logic [31:0]     busy;
    logic            we;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(.XLEN(XLEN)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_alu_valid    (alu_valid),
        .o_alu_ready    (alu_ready),
        .i_alu_rd       (alu_rd),
        .i_alu_data     (alu_data),
        .i_ld_valid     (ld_valid),
        .o_ld_ready     (ld_ready),
        .i_ld_rd        (ld_rd),
        .i_ld_data      (ld_data),
        .i_issue_valid  (issue_valid),
        .i_issue_has_rd (issue_has_rd),
        .i_issue_rd     (issue_rd),
        .i_rs1          (rs1),
        .i_rs2          (rs2),
        .o_stall        (stall),
        .o_busy         (busy),
        .o_we           (we),
        .o_rd           (rd),
        .o_data         (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'hAAAA;
        ld_valid  = 1'b1; ld_rd  = 5'd6; ld_data  = 64'hBBBB;
        issue_valid = 1'b0; issue_has_rd = 1'b0; issue_rd = 5'd0;
        rs1 = 5'd0; rs2 = 5'd0;

        // Reset with both requesters pending
        step();
        step();
        #1;
        chk("rst_alu_ready", alu_ready, 0);
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_we", we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd", rd, 0);
        chk("rst_data", data, 0);

        // Contention: ALU wins the first tie, then strict alternation
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_alu_ready", alu_ready, (i % 2 == 0) ? 1 : 0);
            chk("rr_ld_ready", ld_ready, (i % 2 == 1) ? 1 : 0);
            step();
            chk("rr_we", we, 1);
            chk("rr_rd", rd, (i % 2 == 0) ? 5 : 6);
            chk("rr_data", data, (i % 2 == 0) ? 64'hAAAA : 64'hBBBB);
        end
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
        step();
        chk("idle_we", we, 0);
        chk("idle_rd_hold", rd, 6);
        chk("idle_data_hold", data, 64'hBBBB);

        // RAW on register 7
        issue_valid = 1'b1; issue_has_rd = 1'b1; issue_rd = 5'd7;
        #1;
        chk("raw_issue_nostall", stall, 0);
        step();
        chk("raw_busy7", busy, 32'h0000_0080);
        issue_has_rd = 1'b0; issue_rd = 5'd0; rs1 = 5'd7;
        #1;
        chk("raw_stall", stall, 1);
        issue_valid = 1'b0;
        #1;
        chk("raw_no_issue_no_stall", stall, 0);
        issue_valid = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h77;
        #1;
        chk("raw_alu_ready", alu_ready, 1);
        step();
        alu_valid = 1'b0;
        chk("raw_we", we, 1);
        chk("raw_we_rd", rd, 7);
        chk("raw_stall_during_we", stall, 1);
        step();
        chk("raw_stall_released", stall, 0);
        chk("raw_busy_cleared", busy, 0);
        chk("raw_we_single", we, 0);
        issue_valid = 1'b0; rs1 = 5'd0;

        // x0: issue rd=0 and a load to x0
        issue_valid = 1'b1; issue_has_rd = 1'b1; issue_rd = 5'd0;
        #1;
        chk("x0_nostall", stall, 0);
        step();
        issue_valid = 1'b0;
        chk("x0_busy", busy, 0);
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 64'h1234;
        #1;
        chk("x0_ld_ready", ld_ready, 1);
        step();
        ld_valid = 1'b0;
        chk("x0_we", we, 0);
        chk("x0_busy_after", busy, 0);

        // WAW on register 3
        issue_valid = 1'b1; issue_has_rd = 1'b1; issue_rd = 5'd3;
        step();
        chk("waw_busy3", busy, 32'h0000_0008);
        rs1 = 5'd1; rs2 = 5'd1;
        #1;
        chk("waw_stall", stall, 1);
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h33;
        step();
        alu_valid = 1'b0;
        chk("waw_we_rd", rd, 3);
        chk("waw_stall_during_we", stall, 1);
        step();
        chk("waw_stall_released", stall, 0);
        issue_valid = 1'b0; rs1 = 5'd0; rs2 = 5'd0;
        step();
        chk("waw_busy_clear", busy, 0);

        // Reset in the middle of a write with busy {4,9}
        issue_valid = 1'b1; issue_has_rd = 1'b1; issue_rd = 5'd4;
        step();
        issue_rd = 5'd9;
        step();
        issue_valid = 1'b0;
        chk("mid_busy", busy, 32'h0000_0210);
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 64'h44;
        step();
        alu_valid = 1'b0;
        chk("mid_we", we, 1);
        chk("mid_we_rd", rd, 4);
        reset = 1'b1;
        step();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_we", we, 0);
        chk("mid_rst_rd", rd, 0);
        reset = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd5;
        ld_valid  = 1'b1; ld_rd  = 5'd6;
        issue_valid = 1'b1; issue_has_rd = 1'b1; issue_rd = 5'd4; rs1 = 5'd9;
        #1;
        chk("post_rst_alu_wins", alu_ready, 1);
        chk("post_rst_ld_waits", ld_ready, 0);
        chk("post_rst_nostall", stall, 0);
        step();
        alu_valid = 1'b0; ld_valid = 1'b0; issue_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
